mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Two-requester controller for the 512x32 main memory. It arbitrates between a CPU port (A) and a loader/debug port (B), and sequences each accepted transaction into the RAM strobe protocol. The RAM protocol is: read/write/address/data set up with enable low, then enable raised for one cycle, then data captured. The block sits between the CPU memory interface (MAR/MDR side) and the RAM macro, and is the only driver of the RAM's read, write, enable, address and data_in pins.

## Interface
- DATA_WIDTH, 32, word width
- ADDR_WIDTH, 9, address width (512 words)
- clock  in  1  single system clock; all state changes on rising edge
- clear_n  in  1  asynchronous, active-low reset
- a_req, b_req  in  1  request from port A / port B
- a_we, b_we  in  1  1 = write, 0 = read; sampled with req
- a_addr, b_addr  in  ADDR_WIDTH  word address
- a_wdata, b_wdata  in  DATA_WIDTH  write data
- a_grant, b_grant  out  1  one-cycle pulse: request accepted and payload latched
- a_done, b_done  out  1  one-cycle pulse: transaction complete
- a_rdata, b_rdata  out  DATA_WIDTH  read data; valid while x_done is high and held until that port's next read completes
- busy  out  1  high whenever FSM is not IDLE
- mem_read, mem_write  out  1  RAM operation select; never both high
- mem_enable  out  1  RAM strobe; RAM acts on its rising edge
- mem_address  out  ADDR_WIDTH  RAM address
- mem_data_in  out  DATA_WIDTH  RAM write data
- mem_data_out  in  DATA_WIDTH  RAM read data

## Operation
- FSM states: IDLE, SETUP, STROBE, HOLD.
- IDLE: if any req is high, select the winner, latch its we/addr/wdata and owner ID, pulse the winner's grant, then go to SETUP.
  - mem_read and mem_write are 0 in IDLE.
- SETUP: drive mem_address, mem_data_in and mem_read (=~we) or mem_write (=we) from the latch; mem_enable=0; go to STROBE.
- STROBE: same drives; mem_enable=1 for exactly one cycle; go to HOLD.
- HOLD: same drives; mem_enable=0. At the exit edge:
  - on a read, capture mem_data_out into the owner's rdata register;
  - pulse the owner's done;
  - go to IDLE.
- The other port's rdata is never modified.
- The RAM's done output is not used; completion is fixed-latency.
- The RAM override inputs are not driven by this block.
- Arbitration is round-robin using a one-bit last_served register, updated at each grant.
  - Only one req high: that port wins.
  - Both high: the port not last served wins.
  - last_served resets to B, so A wins the first tie.
- Requester rule: hold req and payload stable until grant is seen.
  - Deassert req at the edge following grant unless issuing a new transaction.
  - If req is still high on return to IDLE, it is a new request and its payload must be the new transaction.
- req is ignored outside IDLE; no queuing.

## Timing
- Reset (clear_n low, asynchronous) sets:
  - state to IDLE and last_served to B;
  - every output to 0, including mem_enable, mem_read, mem_write, mem_address, mem_data_in, grants, dones, both rdata registers and busy.
- Reset during STROBE drops mem_enable immediately. Whether the in-flight write landed in the RAM is undefined; the bench must not check it.
- Request sampled high in IDLE at edge E0:
  - grant is high in cycle E0–E1;
  - mem_enable is high in cycle E1–E2;
  - rdata is captured and done is high in cycle E3–E4.
- Latency from sampling edge to done: 3 cycles after E0, with done high for one cycle. Peak throughput is one access per 4 cycles.
- The FSM is back in IDLE during the done cycle, so a pending req is accepted at E4. Back-to-back grants are therefore 4 cycles apart.
- mem_address, mem_data_in, mem_read and mem_write are stable from SETUP through HOLD, covering one full cycle before and one after the enable rising edge.
- busy is high from E0+ to E3; grant and done are registered outputs.
- Address is used modulo 2^ADDR_WIDTH; no out-of-range condition exists.

## Test plan
- Reset: hold clear_n low mid-STROBE -> mem_enable, busy, all grant/done and rdata outputs are 0 immediately; FSM is in IDLE after release.
- Single write then read on A:
  - write addr 0x1F0, data 0xDEADBEEF -> a_grant at E0+, one mem_enable pulse with mem_write=1, a_done at E3+;
  - then read 0x1F0 -> a_rdata = 0xDEADBEEF while a_done is high.
- Simultaneous req (A write 0x005=0x11111111, B read 0x005) from reset:
  - A is granted first; B is granted 4 cycles later;
  - b_rdata = 0x11111111; a_rdata is unchanged.
- Round-robin fairness: A and B both hold req continuously for 8 transactions -> grants alternate A,B,A,B…; no port is granted twice in a row.
- Port isolation and back-to-back: B reads 0x100 (preloaded 0xCAFEF00D) with req held continuously for 3 reads:
  - grants 4 cycles apart;
  - b_rdata = 0xCAFEF00D each time; a_rdata stays 0.
- Protocol checks on every access:
  - mem_read and mem_write are never both 1;
  - mem_enable is high exactly one cycle per grant;
  - mem_address is stable across the SETUP..HOLD window.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Two-port round-robin arbiter that sequences each accepted request into the
// RAM set-up / strobe / hold protocol with fixed three-cycle completion.
module mem_port_arbiter #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 9
) (
   input  logic                  clock,
   input  logic                  clear_n,
   input  logic                  a_req,
   input  logic                  a_we,
   input  logic [ADDR_WIDTH-1:0] a_addr,
   input  logic [DATA_WIDTH-1:0] a_wdata,
   input  logic                  b_req,
   input  logic                  b_we,
   input  logic [ADDR_WIDTH-1:0] b_addr,
   input  logic [DATA_WIDTH-1:0] b_wdata,
   output logic                  a_grant,
   output logic                  b_grant,
   output logic                  a_done,
   output logic                  b_done,
   output logic [DATA_WIDTH-1:0] a_rdata,
   output logic [DATA_WIDTH-1:0] b_rdata,
   output logic                  busy,
   output logic                  mem_read,
   output logic                  mem_write,
   output logic                  mem_enable,
   output logic [ADDR_WIDTH-1:0] mem_address,
   output logic [DATA_WIDTH-1:0] mem_data_in,
   input  logic [DATA_WIDTH-1:0] mem_data_out
);

   typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

   state_t state;
   logic   last_served;   // 1 = port B was granted most recently
   logic   owner;         // 1 = port B owns the transaction in flight
   logic   pick_b;

   // B wins if it is the only requester, or on a tie when A was served last.
   assign pick_b = b_req && (!a_req || !last_served);

   always_ff @(posedge clock or negedge clear_n) begin
      if (!clear_n) begin
         state       <= IDLE;
         last_served <= 1'b1;
         owner       <= 1'b0;
         a_grant     <= 1'b0;
         b_grant     <= 1'b0;
         a_done      <= 1'b0;
         b_done      <= 1'b0;
         a_rdata     <= '0;
         b_rdata     <= '0;
         busy        <= 1'b0;
         mem_read    <= 1'b0;
         mem_write   <= 1'b0;
         mem_enable  <= 1'b0;
         mem_address <= '0;
         mem_data_in <= '0;
      end else begin
         a_grant <= 1'b0;
         b_grant <= 1'b0;
         a_done  <= 1'b0;
         b_done  <= 1'b0;
         case (state)
            IDLE: begin
               if (a_req || b_req) begin
                  // The RAM-side registers double as the payload latch.
                  owner       <= pick_b;
                  last_served <= pick_b;
                  a_grant     <= !pick_b;
                  b_grant     <= pick_b;
                  mem_address <= pick_b ? b_addr : a_addr;
                  mem_data_in <= pick_b ? b_wdata : a_wdata;
                  mem_write   <= pick_b ? b_we : a_we;
                  mem_read    <= pick_b ? !b_we : !a_we;
                  busy        <= 1'b1;
                  state       <= SETUP;
               end
            end
            SETUP: begin
               mem_enable <= 1'b1;
               state      <= STROBE;
            end
            STROBE: begin
               mem_enable <= 1'b0;
               state      <= HOLD;
            end
            HOLD: begin
               if (mem_read) begin
                  if (owner) b_rdata <= mem_data_out;
                  else       a_rdata <= mem_data_out;
               end
               a_done    <= !owner;
               b_done    <= owner;
               mem_read  <= 1'b0;
               mem_write <= 1'b0;
               busy      <= 1'b0;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: behavioural RAM, array-based reference memory,
// round-robin winner prediction, directed scenarios followed by random traffic.
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        clear_n = 1'b0;
   logic        a_req = 1'b0, b_req = 1'b0, a_we = 1'b0, b_we = 1'b0;
   logic [8:0]  a_addr = '0, b_addr = '0;
   logic [31:0] a_wdata = '0, b_wdata = '0;
   logic        a_grant, b_grant, a_done, b_done, busy;
   logic [31:0] a_rdata, b_rdata;
   logic        mem_read, mem_write, mem_enable;
   logic [8:0]  mem_address;
   logic [31:0] mem_data_in;
   logic [31:0] mem_data_out = '0;

   int n_checks = 0;
   int n_fail   = 0;
   int grant_cnt = 0;
   int enable_cnt = 0;

   // Reference state derived from the arbitration and memory rules.
   logic [31:0] ref_mem [512];
   logic [31:0] exp_a_rd = '0, exp_b_rd = '0;
   bit          last_b = 1'b1;

   // Behavioural RAM: acts on the rising edge of its enable.
   logic [31:0] ram [512];

   always #5 clk = ~clk;

   mem_port_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(9)) dut (
      .clock(clk), .clear_n(clear_n),
      .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
      .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
      .a_grant(a_grant), .b_grant(b_grant), .a_done(a_done), .b_done(b_done),
      .a_rdata(a_rdata), .b_rdata(b_rdata), .busy(busy),
      .mem_read(mem_read), .mem_write(mem_write), .mem_enable(mem_enable),
      .mem_address(mem_address), .mem_data_in(mem_data_in),
      .mem_data_out(mem_data_out)
   );

   always @(posedge mem_enable) begin
      if (mem_write)     ram[mem_address] <= mem_data_in;
      else if (mem_read) mem_data_out     <= ram[mem_address];
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (clear_n) begin
         check("rw_exclusive", {31'd0, mem_read & mem_write}, 32'd0);
         if (mem_enable) enable_cnt++;
      end
   end

   task automatic check_all_zero(input string tag);
      check({tag, "_enable"}, {31'd0, mem_enable}, 0);
      check({tag, "_busy"},   {31'd0, busy}, 0);
      check({tag, "_grants"}, {30'd0, a_grant, b_grant}, 0);
      check({tag, "_dones"},  {30'd0, a_done, b_done}, 0);
      check({tag, "_a_rdata"}, a_rdata, 0);
      check({tag, "_b_rdata"}, b_rdata, 0);
      check({tag, "_rw"},     {30'd0, mem_read, mem_write}, 0);
   endtask

   task automatic do_reset();
      clear_n = 1'b0;
      #1;
      check_all_zero("reset");
      #3 clear_n = 1'b1;
      last_b = 1'b1;
      exp_a_rd = '0;
      exp_b_rd = '0;
      @(posedge clk); #1;
   endtask

   task automatic rand_a();
      a_we = 1'($urandom_range(0, 1));
      a_addr = 9'($urandom_range(0, 15));
      a_wdata = $urandom;
   endtask

   task automatic rand_b();
      b_we = 1'($urandom_range(0, 1));
      b_addr = 9'($urandom_range(0, 15));
      b_wdata = $urandom;
   endtask

   // Waits for the next grant and follows that transaction to its done cycle.
   task automatic serve_one(input bit keep, input bit newpay, output int waited);
      bit exp_b;
      logic we;
      logic [8:0] ad;
      logic [31:0] wd;
      exp_b = a_req ? (b_req && !last_b) : 1'b1;
      we = exp_b ? b_we : a_we;
      ad = exp_b ? b_addr : a_addr;
      wd = exp_b ? b_wdata : a_wdata;
      waited = 0;
      do begin
         @(posedge clk); #1;
         waited++;
      end while (!(a_grant || b_grant) && waited < 8);
      check("grant_seen", {31'd0, a_grant | b_grant}, 1);
      check("grant_a", {31'd0, a_grant}, {31'd0, !exp_b});
      check("grant_b", {31'd0, b_grant}, {31'd0, exp_b});
      $display("grant port=%s we=%0d addr=%03h wdata=%08h wait=%0d",
               exp_b ? "B" : "A", we, ad, wd, waited);
      last_b = exp_b;
      grant_cnt++;
      if (we) ref_mem[ad] = wd;
      else if (exp_b) exp_b_rd = ref_mem[ad];
      else exp_a_rd = ref_mem[ad];
      if (!keep) begin
         if (exp_b) b_req = 1'b0; else a_req = 1'b0;
      end else if (newpay) begin
         if (exp_b) rand_b(); else rand_a();
      end
      // SETUP
      check("setup_busy", {31'd0, busy}, 1);
      check("setup_enable", {31'd0, mem_enable}, 0);
      check("setup_addr", {23'd0, mem_address}, {23'd0, ad});
      check("setup_rw", {30'd0, mem_read, mem_write}, {30'd0, !we, we});
      if (we) check("setup_wdata", mem_data_in, wd);
      @(posedge clk); #1;
      check("strobe_enable", {31'd0, mem_enable}, 1);
      check("strobe_addr", {23'd0, mem_address}, {23'd0, ad});
      check("strobe_done", {30'd0, a_done, b_done}, 0);
      @(posedge clk); #1;
      check("hold_enable", {31'd0, mem_enable}, 0);
      check("hold_addr", {23'd0, mem_address}, {23'd0, ad});
      check("hold_rw", {30'd0, mem_read, mem_write}, {30'd0, !we, we});
      check("hold_busy", {31'd0, busy}, 1);
      @(posedge clk); #1;
      check("done_pair", {30'd0, a_done, b_done}, {30'd0, !exp_b, exp_b});
      check("done_busy", {31'd0, busy}, 0);
      check("done_rw", {30'd0, mem_read, mem_write}, 0);
      check("a_rdata", a_rdata, exp_a_rd);
      check("b_rdata", b_rdata, exp_b_rd);
      $display("done  port=%s a_rdata=%08h b_rdata=%08h", exp_b ? "B" : "A", a_rdata, b_rdata);
   endtask

   initial begin
      int w;
      bit prev_b;
      for (int i = 0; i < 512; i++) begin
         ram[i] = '0;
         ref_mem[i] = '0;
      end
      ram[9'h100] = 32'hCAFEF00D;
      ref_mem[9'h100] = 32'hCAFEF00D;

      // Reset state
      #2;
      check_all_zero("init");
      #2 clear_n = 1'b1;
      @(posedge clk); #1;

      // Reset in the middle of the strobe cycle
      a_req = 1'b1; a_we = 1'b0; a_addr = 9'h100;
      @(posedge clk); #1;
      check("rst_grant", {31'd0, a_grant}, 1);
      a_req = 1'b0;
      @(posedge clk); #1;
      check("rst_strobe_enable", {31'd0, mem_enable}, 1);
      do_reset();
      check("rst_idle_busy", {31'd0, busy}, 0);
      check("rst_idle_grant", {30'd0, a_grant, b_grant}, 0);

      // Single write then read on A
      a_req = 1'b1; a_we = 1'b1; a_addr = 9'h1F0; a_wdata = 32'hDEADBEEF;
      serve_one(1'b0, 1'b0, w);
      a_req = 1'b1; a_we = 1'b0;
      serve_one(1'b0, 1'b0, w);
      check("a_read_back", a_rdata, 32'hDEADBEEF);

      // Simultaneous requests straight after reset
      do_reset();
      a_req = 1'b1; a_we = 1'b1; a_addr = 9'h005; a_wdata = 32'h11111111;
      b_req = 1'b1; b_we = 1'b0; b_addr = 9'h005;
      serve_one(1'b0, 1'b0, w);
      serve_one(1'b0, 1'b0, w);
      check("tie_b_spacing", w, 1);
      check("tie_b_rdata", b_rdata, 32'h11111111);
      check("tie_a_rdata", a_rdata, 32'h0);

      // Round-robin with both requests held
      a_req = 1'b1; a_we = 1'b1; a_addr = 9'h010; a_wdata = 32'h0A0A0A0A;
      b_req = 1'b1; b_we = 1'b0; b_addr = 9'h010;
      prev_b = last_b;
      for (int i = 0; i < 8; i++) begin
         serve_one(1'b1, 1'b0, w);
         check("rr_alternate", {31'd0, last_b}, {31'd0, !prev_b});
         prev_b = last_b;
      end
      a_req = 1'b0; b_req = 1'b0;

      // Back-to-back reads on B with req held
      b_req = 1'b1; b_we = 1'b0; b_addr = 9'h100;
      for (int i = 0; i < 3; i++) begin
         serve_one(1'b1, 1'b0, w);
         if (i > 0) check("b2b_spacing", w, 1);
         check("b2b_b_rdata", b_rdata, 32'hCAFEF00D);
         check("b2b_a_rdata", a_rdata, 32'h0);
      end
      b_req = 1'b0;

      // Random traffic
      for (int i = 0; i < 40; i++) begin
         if (!a_req && $urandom_range(0, 1) == 1) begin rand_a(); a_req = 1'b1; end
         if (!b_req && $urandom_range(0, 1) == 1) begin rand_b(); b_req = 1'b1; end
         if (!a_req && !b_req) begin rand_a(); a_req = 1'b1; end
         serve_one(1'($urandom_range(0, 1)), 1'b1, w);
      end
      a_req = 1'b0; b_req = 1'b0;
      @(posedge clk); #1;
      check("final_idle", {31'd0, busy}, 0);
      check("enable_per_grant", enable_cnt, grant_cnt);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
